sm_controller: RTL
==================

Name: sm_controller

Overview:
- Moore FSM that sequences the 16-bit register-file/ALU datapath, one instruction at a time.
- Consumes the instruction decoder's opcode/op fields.
- Drives the decoder's nsel register select and the datapath load/mux/write strobes.
- Handshakes with the top level through start (s) and wait (w).

Parameters:
- START_LEVEL, 1, 1: s is level-sensitive and a held s re-launches on the edge after completion; 0: a new start needs s low for at least one WAIT cycle after the previous instruction.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces WAIT
- s  in  1  start request, sampled only in WAIT
- opcode  in  3  instruction[15:13] from the decoder
- op  in  2  instruction[12:11] from the decoder
- w  out  1  high only in WAIT (ready for s)
- done  out  1  high during the final execute cycle of an instruction
- nsel  out  3  one-hot register select to the decoder: 001=Rm, 010=Rd, 100=Rn, 000=none
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C register
- loads  out  1  load status flags
- asel  out  1  1 forces the ALU A input to 0
- bsel  out  1  1 selects sximm5 for the B input (always 0 in this ISA subset)
- vsel  out  2  register-file write source: 00=C, 10=sximm8, others reserved
- write  out  1  register-file write enable
- err  out  1  illegal-instruction trap (see Optional Feature)

Behaviour:
- State register is async-reset to WAIT. All outputs decode from state (and the latched class) only.
- Reset values: w=1, all other outputs 0, nsel=000.
- Accept: in WAIT with s=1 (and, when START_LEVEL=0, the s-low condition met), the next edge enters DECODE and latches opcode/op into internal registers. Later changes to opcode/op are ignored until the next accept.
- States and outputs (outputs not listed are 0):
  - WAIT: w=1.
  - DECODE: none.
  - GET_A: nsel=100, loada=1.
  - GET_B: nsel=001, loadb=1.
  - ALU: loadc=1; asel=1 only for MOV Rd,Rm.
  - CMP: loads=1, done=1.
  - WR_REG: nsel=010, vsel=00, write=1, done=1.
  - WR_IMM: nsel=100, vsel=10, write=1, done=1.
- Transitions out of DECODE, by latched {opcode,op}:
  - 110_10 MOV Rn,#imm8: WR_IMM→WAIT. w low for 2 cycles.
  - 110_00 MOV Rd,Rm: GET_B→ALU→WR_REG→WAIT. 4 cycles.
  - 101_11 MVN: GET_B→ALU→WR_REG→WAIT. 4 cycles, asel=0.
  - 101_00 ADD and 101_10 AND: GET_A→GET_B→ALU→WR_REG→WAIT. 5 cycles.
  - 101_01 CMP: GET_A→GET_B→CMP→WAIT. 4 cycles.
  - any other combination: illegal (see Optional Feature).
- s is ignored outside WAIT. s held high with START_LEVEL=1 yields back-to-back instructions with exactly one WAIT cycle between them.
- Reset mid-instruction: outputs drop to reset values immediately, without waiting for clk. A partially executed instruction is abandoned with no write. Latched fields clear to 0.
- No combinational path from s, opcode or op to any output.
- ALUop and shift are not generated here; they come from the decoder.

Optional Feature:
- SM_ILLEGAL_TRAP_EN.
- Defined: an illegal combination in DECODE goes to ERR. In ERR: err=1, w=0, all strobes 0. ERR is left only by reset.
- Undefined: an illegal combination in DECODE returns to WAIT as a NOP (w low for 1 cycle, no strobes). err is tied 0 and ERR is not synthesized.

Test Plan:
- Reset asserted between clock edges during ADD GET_B → w=1, loadb=0, nsel=000 immediately. After release, one WAIT cycle then accept on s=1.
- opcode=110, op=10, s pulse for 1 cycle → DECODE, then WR_IMM with nsel=100, vsel=10, write=1, done=1; w high again on the 3rd edge.
- opcode=101, op=00; opcode changed to 000 after accept → GET_A(nsel=100, loada), GET_B(nsel=001, loadb), ALU(loadc, asel=0), WR_REG(nsel=010, write); w low for exactly 5 cycles.
- opcode=101, op=01 → loads=1 for one cycle in CMP; write never asserted; loadc never asserted.
- opcode=110, op=00 → asel=1 during ALU. Repeat with opcode=101, op=11 → asel=0 during ALU; both 4 cycles.
- opcode=111, op=00 → without macro: w low for 1 cycle, zero strobes. With SM_ILLEGAL_TRAP_EN: err=1 and w=0 persist for 20 cycles until reset. START_LEVEL=0 with s held high → no second launch until s drops.

Source files
------------

// File: rtl/sm_controller.sv
// sm_controller: Moore FSM sequencing the register-file/ALU datapath; define SM_ILLEGAL_TRAP_EN to trap illegal instructions in ERR.
module sm_controller #(
    parameter int START_LEVEL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic       done,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       err
);
    typedef enum logic [3:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_CMP, S_WR_REG, S_WR_IMM
`ifdef SM_ILLEGAL_TRAP_EN
        , S_ERR
`endif
    } state_t;
    state_t st, nxt;
    logic [4:0] cls;
    logic armed, accept;
    assign accept = (st == S_WAIT) && s && ((START_LEVEL != 0) || armed);
    // armed records that s was seen low in WAIT since the last accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= S_WAIT;
            cls <= 5'd0;
            armed <= 1'b1;
        end else begin
            st <= nxt;
            if (accept) cls <= {opcode, op};
            armed <= accept ? 1'b0 : ((st == S_WAIT && !s) ? 1'b1 : armed);
        end
    end
    always_comb begin
        nxt = st;
        w = 1'b0;
        done = 1'b0;
        nsel = 3'b000;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        asel = 1'b0;
        bsel = 1'b0;
        vsel = 2'b00;
        write = 1'b0;
        err = 1'b0;
        case (st)
            S_WAIT: begin
                w = 1'b1;
                nxt = accept ? S_DECODE : S_WAIT;
            end
            S_DECODE: begin
                case (cls)
                    5'b110_10: nxt = S_WR_IMM;
                    5'b110_00, 5'b101_11: nxt = S_GET_B;
                    5'b101_00, 5'b101_10, 5'b101_01: nxt = S_GET_A;
`ifdef SM_ILLEGAL_TRAP_EN
                    default: nxt = S_ERR;
`else
                    default: nxt = S_WAIT;
`endif
                endcase
            end
            S_GET_A: begin
                nsel = 3'b100;
                loada = 1'b1;
                nxt = S_GET_B;
            end
            S_GET_B: begin
                nsel = 3'b001;
                loadb = 1'b1;
                nxt = (cls == 5'b101_01) ? S_CMP : S_ALU;
            end
            S_ALU: begin
                loadc = 1'b1;
                asel = (cls == 5'b110_00);
                nxt = S_WR_REG;
            end
            S_CMP: begin
                loads = 1'b1;
                done = 1'b1;
                nxt = S_WAIT;
            end
            S_WR_REG: begin
                nsel = 3'b010;
                write = 1'b1;
                done = 1'b1;
                nxt = S_WAIT;
            end
            S_WR_IMM: begin
                nsel = 3'b100;
                vsel = 2'b10;
                write = 1'b1;
                done = 1'b1;
                nxt = S_WAIT;
            end
`ifdef SM_ILLEGAL_TRAP_EN
            S_ERR: err = 1'b1;
`endif
            default: nxt = S_WAIT;
        endcase
    end
endmodule
